// File: rtl/pipe_control_unit.sv
// pipe_control_unit: ID-stage decode plus ID/EX, EX/MEM, MEM/WB control pipeline
// with load-use stall, jump redirect and taken-branch squash.
module pipe_control_unit #(
    parameter int REG_AW = 5,
    parameter int OP_W   = 6,
    parameter int HAZ_EN = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       instr_i,
    input  logic              branch_taken_i,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              ifid_flush_o,
    output logic              jump_o,
    output logic              stall_o,
    output logic [OP_W:0]     ex_ctrl_o,
    output logic [2:0]        mem_ctrl_o,
    output logic [2:0]        wb_ctrl_o,
    output logic [REG_AW-1:0] wb_dst_o
);
    typedef struct packed {
        logic [OP_W-1:0]   alu_op;
        logic              alu_src;
        logic              branch;
        logic              mem_read;
        logic              mem_write;
        logic              reg_write;
        logic [1:0]        m2r;
        logic [REG_AW-1:0] dst;
    } bundle_t;

    bundle_t id, idex, exmem, memwb;
    logic [5:0] op;
    logic [REG_AW-1:0] rs, rt, rd;
    logic known, uses_rt, is_jump, hazard, unused_bits;

    assign op = instr_i[31:26];
    assign rs = REG_AW'(instr_i[25:21]);
    assign rt = REG_AW'(instr_i[20:16]);
    assign rd = REG_AW'(instr_i[15:11]);
    assign unused_bits = ^instr_i[10:0];
    assign known = op inside {6'h00, 6'h08, 6'h0a, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03};
    assign uses_rt = op inside {6'h00, 6'h04, 6'h05, 6'h2b};
    assign is_jump = op inside {6'h02, 6'h03};

    always_comb begin
        id = '0;
        case (op)
            6'h00: begin id.reg_write = |instr_i; id.dst = rd; end
            6'h08, 6'h0a: begin id.alu_src = 1'b1; id.reg_write = 1'b1; id.dst = rt; end
            6'h23: begin
                id.alu_src = 1'b1; id.mem_read = 1'b1; id.m2r = 2'd1;
                id.reg_write = 1'b1; id.dst = rt;
            end
            6'h2b: begin id.alu_src = 1'b1; id.mem_write = 1'b1; end
            6'h04, 6'h05: id.branch = 1'b1;
            6'h03: begin id.reg_write = 1'b1; id.m2r = 2'd2; id.dst = REG_AW'(5'd31); end
            default: ;
        endcase
        id.alu_op = known ? OP_W'(op) : '0;
        if (id.dst == '0) id.reg_write = 1'b0;
    end

    // A taken branch outranks the stall: the instruction in ID is squashed anyway.
    assign hazard = (HAZ_EN != 0) && !rst_i && !branch_taken_i && idex.mem_read && (idex.dst != '0)
                    && (idex.dst == rs || (uses_rt && idex.dst == rt));

    assign stall_o      = hazard;
    assign jump_o       = !rst_i && !branch_taken_i && !hazard && is_jump;
    assign pc_write_o   = !rst_i && !hazard;
    assign ifid_write_o = !rst_i && !hazard;
    assign ifid_flush_o = rst_i || branch_taken_i || jump_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idex  <= '0;
            exmem <= '0;
            memwb <= '0;
        end else begin
            idex  <= (branch_taken_i || hazard) ? '0 : id;
            exmem <= branch_taken_i ? '0 : idex;
            memwb <= exmem;
        end
    end

    assign ex_ctrl_o  = {idex.alu_op, idex.alu_src};
    assign mem_ctrl_o = {exmem.branch, exmem.mem_read, exmem.mem_write};
    assign wb_ctrl_o  = {memwb.reg_write, memwb.m2r};
    assign wb_dst_o   = memwb.dst;
endmodule
